// File: rtl/payload_extractor.sv
// Payload extractor: takes the length byte after a header detect, buffers L bytes,
// then drains them on a valid/ready stream. Optional macro PAYLOAD_XOR_CHECK_EN adds a trailing XOR check byte.
module payload_extractor #(
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned AW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       data_valid_in,
  input  logic       detected_in,
  output logic [7:0] pay_data_out,
  output logic       pay_valid_out,
  input  logic       pay_ready_in,
  output logic       pay_last_out,
  output logic       frame_err_out,
  output logic       busy_out
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 8;

`ifdef PAYLOAD_XOR_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DRAIN   = 3'd3,
    S_CHECK   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [7:0]     buffer [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  len_q, len_d;
  logic           wr_en;
  logic           err_d, valid_d, last_d;
  logic [7:0]     data_d;
`ifdef PAYLOAD_XOR_CHECK_EN
  logic [7:0]     xor_q, xor_d;
`endif

  logic accept, len_bad, drain_done;
  assign accept     = data_valid_in & enable;
  assign len_bad    = (data_in == 8'd0) || (data_in > 8'(MAX_LEN));
  assign drain_done = pay_valid_out & pay_ready_in & pay_last_out;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (detected_in) state_d = S_LEN;
      S_LEN:     if (accept) state_d = len_bad ? S_IDLE : S_PAYLOAD;
`ifdef PAYLOAD_XOR_CHECK_EN
      S_PAYLOAD: if (accept && cnt_q == 8'd1) state_d = S_CHECK;
      S_CHECK:   if (accept) state_d = (data_in == xor_q) ? S_DRAIN : S_IDLE;
`else
      S_PAYLOAD: if (accept && cnt_q == 8'd1) state_d = S_DRAIN;
`endif
      S_DRAIN:   if (drain_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; rd_ptr points at the next byte to present
  always_comb begin
    err_d    = 1'b0;
    valid_d  = pay_valid_out;
    data_d   = pay_data_out;
    last_d   = pay_last_out;
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
`ifdef PAYLOAD_XOR_CHECK_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      S_LEN: if (accept) begin
        if (len_bad) begin
          err_d = 1'b1;
        end else begin
          cnt_d = data_in;
          len_d = data_in;
        end
`ifdef PAYLOAD_XOR_CHECK_EN
        xor_d = 8'h00;
`endif
      end
      S_PAYLOAD: if (accept) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q - 8'd1;
`ifdef PAYLOAD_XOR_CHECK_EN
        xor_d    = xor_q ^ data_in;
`endif
      end
`ifdef PAYLOAD_XOR_CHECK_EN
      S_CHECK: if (accept && data_in != xor_q) begin
        err_d    = 1'b1;
        wr_ptr_d = '0;
      end
`endif
      S_DRAIN: begin
        if (drain_done) begin
          valid_d  = 1'b0;
          last_d   = 1'b0;
          data_d   = 8'h00;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else if (!pay_valid_out || pay_ready_in) begin
          valid_d  = 1'b1;
          data_d   = buffer[rd_ptr_q];
          last_d   = (32'(rd_ptr_q) + 32'd1) == 32'(len_q);
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pay_data_out  <= 8'h00;
      pay_valid_out <= 1'b0;
      pay_last_out  <= 1'b0;
      frame_err_out <= 1'b0;
      busy_out      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
`ifdef PAYLOAD_XOR_CHECK_EN
      xor_q         <= 8'h00;
`endif
    end else begin
      pay_data_out  <= data_d;
      pay_valid_out <= valid_d;
      pay_last_out  <= last_d;
      frame_err_out <= err_d;
      busy_out      <= (state_d != S_IDLE);
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
`ifdef PAYLOAD_XOR_CHECK_EN
      xor_q         <= xor_d;
`endif
    end
  end

  // Payload storage; contents are only meaningful below wr_ptr
  always_ff @(posedge clk) begin
    if (wr_en) buffer[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_payload_extractor.sv
// Directed self-checking bench for payload_extractor (default MAX_LEN=15, AW=4).
module tb_payload_extractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid_in = 1'b0;
  logic       detected_in = 1'b0;
  logic [7:0] pay_data_out;
  logic       pay_valid_out;
  logic       pay_ready_in = 1'b1;
  logic       pay_last_out;
  logic       frame_err_out;
  logic       busy_out;

  int total = 0;
  int bad   = 0;
  logic [7:0] got_q [$];
  logic       got_last_q [$];
  int err_cnt = 0;
  int valid_cycles = 0;

  payload_extractor dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .data_valid_in(data_valid_in), .detected_in(detected_in),
    .pay_data_out(pay_data_out), .pay_valid_out(pay_valid_out),
    .pay_ready_in(pay_ready_in), .pay_last_out(pay_last_out),
    .frame_err_out(frame_err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // Record every stream transfer and error pulse seen at the clock edge
  always @(posedge clk) begin
    if (pay_valid_out && pay_ready_in) begin
      got_q.push_back(pay_data_out);
      got_last_q.push_back(pay_last_out);
    end
    if (frame_err_out) err_cnt++;
    if (pay_valid_out) valid_cycles++;
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic e, input logic det);
    data_in = d; data_valid_in = v; enable = e; detected_in = det;
    @(posedge clk); #1;
    data_in = 8'h00; data_valid_in = 1'b0; enable = 1'b1; detected_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    got_q.delete(); got_last_q.delete(); err_cnt = 0; valid_cycles = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_out || pay_valid_out) && n < 100) begin step(); n++; end
    total++;
    if (busy_out || pay_valid_out) begin
      bad++; $display("FAIL %s_timeout: busy=%b valid=%b, want both 0", tag, busy_out, pay_valid_out);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    total++;
    if ({pay_data_out, pay_valid_out, pay_last_out, frame_err_out, busy_out} !== 12'h000) begin
      bad++; $display("FAIL reset_outputs: data=%h valid=%b last=%b err=%b busy=%b, want all 0",
                      pay_data_out, pay_valid_out, pay_last_out, frame_err_out, busy_out);
    end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    total++;
    if (busy_out !== 1'b1) begin bad++; $display("FAIL basic_busy_len: got %b want 1", busy_out); end
    drive(8'h03, 1'b1, 1'b1, 1'b0);
    drive(8'h11, 1'b1, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b1, 1'b0);
    drive(8'h33, 1'b1, 1'b1, 1'b0);
`ifdef PAYLOAD_XOR_CHECK_EN
    drive(8'h00, 1'b1, 1'b1, 1'b0);
`endif
    total++;
    if (pay_valid_out !== 1'b0) begin bad++; $display("FAIL basic_drain_entry: valid=%b want 0", pay_valid_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pay_valid_out !== 1'b1 || pay_data_out !== exp[i] || pay_last_out !== (i == 2)) begin
        bad++; $display("FAIL basic_out%0d: valid=%b data=%h last=%b want 1 %h %b",
                        i, pay_valid_out, pay_data_out, pay_last_out, exp[i], i == 2);
      end
    end
    step();
    total++;
    if (pay_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL basic_end: valid=%b busy=%b want 0 0", pay_valid_out, busy_out);
    end
    total++;
    if (got_q.size() != 3 || err_cnt != 0) begin
      bad++; $display("FAIL basic_count: transfers=%0d errs=%0d want 3 0", got_q.size(), err_cnt);
    end
  endtask

  task automatic test_len_err();
    logic [7:0] lens [2] = '{8'h00, 8'h10};
    for (int k = 0; k < 2; k++) begin
      clear_log();
      drive(8'h00, 1'b0, 1'b1, 1'b1);
      drive(lens[k], 1'b1, 1'b1, 1'b0);
      total++;
      if (frame_err_out !== 1'b1 || busy_out !== 1'b0) begin
        bad++; $display("FAIL lenerr_pulse_%h: err=%b busy=%b want 1 0", lens[k], frame_err_out, busy_out);
      end
      drive(8'h44, 1'b1, 1'b1, 1'b0);
      total++;
      if (frame_err_out !== 1'b0) begin bad++; $display("FAIL lenerr_width_%h: err=%b want 0", lens[k], frame_err_out); end
      drive(8'h55, 1'b1, 1'b1, 1'b0);
      step(); step();
      total++;
      if (err_cnt != 1 || valid_cycles != 0 || busy_out !== 1'b0) begin
        bad++; $display("FAIL lenerr_count_%h: errs=%0d valid_cycles=%0d busy=%b want 1 0 0",
                        lens[k], err_cnt, valid_cycles, busy_out);
      end
    end
  endtask

  task automatic test_max_len();
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h0F, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) drive(8'(i), 1'b1, 1'b1, 1'b0);
`ifdef PAYLOAD_XOR_CHECK_EN
    drive(8'h00, 1'b1, 1'b1, 1'b0);
`endif
    wait_idle("maxlen");
    total++;
    if (got_q.size() != 15) begin bad++; $display("FAIL maxlen_count: got %0d want 15", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 15; i++) begin
      total++;
      if (got_q[i] !== 8'(i + 1) || got_last_q[i] !== (i == 14)) begin
        bad++; $display("FAIL maxlen_byte%0d: data=%h last=%b want %h %b", i, got_q[i], got_last_q[i], 8'(i + 1), i == 14);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h02, 1'b1, 1'b1, 1'b0);
    drive(8'hA1, 1'b1, 1'b1, 1'b0);
    drive(8'hB2, 1'b1, 1'b1, 1'b0);
`ifdef PAYLOAD_XOR_CHECK_EN
    drive(8'h13, 1'b1, 1'b1, 1'b0);
`endif
    pay_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pay_valid_out !== 1'b1 || pay_data_out !== 8'hA1 || pay_last_out !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b data=%h last=%b want 1 a1 0", i, pay_valid_out, pay_data_out, pay_last_out);
      end
    end
    pay_ready_in = 1'b1;
    step();
    total++;
    if (pay_valid_out !== 1'b1 || pay_data_out !== 8'hB2 || pay_last_out !== 1'b1) begin
      bad++; $display("FAIL bp_second: valid=%b data=%h last=%b want 1 b2 1", pay_valid_out, pay_data_out, pay_last_out);
    end
    step();
    total++;
    if (got_q.size() != 2 || got_q[0] !== 8'hA1 || got_q[got_q.size()-1] !== 8'hB2 || pay_valid_out !== 1'b0) begin
      bad++; $display("FAIL bp_order: transfers=%0d first=%h last=%h valid=%b want 2 a1 b2 0",
                      got_q.size(), got_q[0], got_q[got_q.size()-1], pay_valid_out);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h99, 1'b1, 1'b0, 1'b0);
    drive(8'h03, 1'b1, 1'b1, 1'b0);
    drive(8'hEE, 1'b0, 1'b1, 1'b0);
    drive(8'h11, 1'b1, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    total++;
    if (busy_out !== 1'b1 || frame_err_out !== 1'b0) begin
      bad++; $display("FAIL gaps_detect_mid: busy=%b err=%b want 1 0", busy_out, frame_err_out);
    end
    drive(8'h22, 1'b1, 1'b1, 1'b0);
    drive(8'h77, 1'b1, 1'b0, 1'b0);
    drive(8'h33, 1'b1, 1'b1, 1'b0);
`ifdef PAYLOAD_XOR_CHECK_EN
    drive(8'h00, 1'b1, 1'b1, 1'b0);
`endif
    wait_idle("gaps");
    total++;
    if (got_q.size() != 3 || valid_cycles != 3 || err_cnt != 0) begin
      bad++; $display("FAIL gaps_count: transfers=%0d valid_cycles=%0d errs=%0d want 3 3 0", got_q.size(), valid_cycles, err_cnt);
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++;
      if (got_q[i] !== exp[i] || got_last_q[i] !== (i == 2)) begin
        bad++; $display("FAIL gaps_byte%0d: data=%h last=%b want %h %b", i, got_q[i], got_last_q[i], exp[i], i == 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h04, 1'b1, 1'b1, 1'b0);
    drive(8'h01, 1'b1, 1'b1, 1'b0);
    drive(8'h02, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({pay_data_out, pay_valid_out, pay_last_out, frame_err_out, busy_out} !== 12'h000) begin
      bad++; $display("FAIL rstmid_outputs: data=%h valid=%b last=%b err=%b busy=%b want all 0",
                      pay_data_out, pay_valid_out, pay_last_out, frame_err_out, busy_out);
    end
    @(posedge clk); #1 reset = 1'b1;
    drive(8'h03, 1'b1, 1'b1, 1'b0);
    drive(8'h04, 1'b1, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h02, 1'b1, 1'b1, 1'b0);
    drive(8'hAB, 1'b1, 1'b1, 1'b0);
    drive(8'hCD, 1'b1, 1'b1, 1'b0);
`ifdef PAYLOAD_XOR_CHECK_EN
    drive(8'h66, 1'b1, 1'b1, 1'b0);
`endif
    wait_idle("rstmid");
    total++;
    if (got_q.size() != 2 || got_q[0] !== 8'hAB || got_q[got_q.size()-1] !== 8'hCD) begin
      bad++; $display("FAIL rstmid_frame: transfers=%0d first=%h last=%h want 2 ab cd",
                      got_q.size(), got_q[0], got_q[got_q.size()-1]);
    end
    // Reset while a byte is being presented under backpressure
    clear_log();
    pay_ready_in = 1'b0;
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h01, 1'b1, 1'b1, 1'b0);
    drive(8'h5A, 1'b1, 1'b1, 1'b0);
`ifdef PAYLOAD_XOR_CHECK_EN
    drive(8'h5A, 1'b1, 1'b1, 1'b0);
`endif
    step();
    total++;
    if (pay_valid_out !== 1'b1 || pay_data_out !== 8'h5A || pay_last_out !== 1'b1) begin
      bad++; $display("FAIL rstdrain_pre: valid=%b data=%h last=%b want 1 5a 1", pay_valid_out, pay_data_out, pay_last_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({pay_data_out, pay_valid_out, pay_last_out, busy_out} !== 11'h000) begin
      bad++; $display("FAIL rstdrain_outputs: data=%h valid=%b last=%b busy=%b want all 0",
                      pay_data_out, pay_valid_out, pay_last_out, busy_out);
    end
    @(posedge clk); #1 reset = 1'b1;
    pay_ready_in = 1'b1;
    step(); step(); step();
    total++;
    if (got_q.size() != 0 || valid_cycles != 0) begin
      bad++; $display("FAIL rstdrain_residue: transfers=%0d valid_cycles=%0d want 0 0", got_q.size(), valid_cycles);
    end
  endtask

`ifdef PAYLOAD_XOR_CHECK_EN
  task automatic test_xor();
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h02, 1'b1, 1'b1, 1'b0);
    drive(8'h0F, 1'b1, 1'b1, 1'b0);
    drive(8'hF0, 1'b1, 1'b1, 1'b0);
    drive(8'hFF, 1'b1, 1'b1, 1'b0);
    wait_idle("xor_good");
    total++;
    if (got_q.size() != 2 || got_q[0] !== 8'h0F || got_q[got_q.size()-1] !== 8'hF0 || err_cnt != 0) begin
      bad++; $display("FAIL xor_good: transfers=%0d first=%h last=%h errs=%0d want 2 0f f0 0",
                      got_q.size(), got_q[0], got_q[got_q.size()-1], err_cnt);
    end
    clear_log();
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h02, 1'b1, 1'b1, 1'b0);
    drive(8'h0F, 1'b1, 1'b1, 1'b0);
    drive(8'hF0, 1'b1, 1'b1, 1'b0);
    drive(8'h00, 1'b1, 1'b1, 1'b0);
    total++;
    if (frame_err_out !== 1'b1 || busy_out !== 1'b0) begin
      bad++; $display("FAIL xor_bad_pulse: err=%b busy=%b want 1 0", frame_err_out, busy_out);
    end
    step(); step(); step();
    total++;
    if (err_cnt != 1 || valid_cycles != 0) begin
      bad++; $display("FAIL xor_bad_count: errs=%0d valid_cycles=%0d want 1 0", err_cnt, valid_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_err();
    test_max_len();
    test_backpressure();
    test_gaps();
    test_reset_mid();
`ifdef PAYLOAD_XOR_CHECK_EN
    test_xor();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
